// File: rtl/div16_seq.sv
// Purpose : unsigned sequential divider using restoring shift-subtract, one quotient bit per cycle.
// Latency : WIDTH cycles from acceptance to out_valid; a zero divisor takes 1 cycle.
// Backpr. : single operation in flight; in_ready low until the result is taken; result held while out_ready=0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (dividend, divisor)
//   out_valid / out_ready result handshake (quotient, remainder, div_by_zero)
module div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend bits shift out MSB first, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             zpend_q, zpend_d;   // zero-divisor op accepted, result published on the next edge

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH:0]   prem_nxt;
    logic             unused_prem_msb;

    // The partial remainder is always below the divisor between iterations,
    // so its MSB is zero there; only the trial value needs the extra bit.
    assign unused_prem_msb = prem_q[WIDTH];

    assign trial    = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs_q};
    assign ge       = (trial >= {1'b0, dvs_q});
    assign prem_nxt = ge ? diff : trial;

    assign in_ready    = (state_q == ST_IDLE) && !zpend_q;
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        zpend_d = zpend_q;

        case (state_q)
            ST_IDLE: begin
                if (zpend_q) begin
                    state_d = ST_DONE;
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    zpend_d = 1'b0;
                end else if (in_valid) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        zpend_d = 1'b1;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                prem_d = prem_nxt;
                dvd_d  = {dvd_q[WIDTH-2:0], ge};
                cnt_d  = cnt_q + CW'(1);
                // Results are published only when the last bit is resolved,
                // so intermediate values never reach the outputs.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    quo_d   = {dvd_q[WIDTH-2:0], ge};
                    rem_d   = prem_nxt[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            zpend_q <= zpend_d;
        end
    end

endmodule
